// File: rtl/axil_init_pkg.sv
// Shared types for the AXI-Lite command initiator.
//   state_t : initiator FSM states
//   OKAY/EXOKAY/SLVERR/DECERR : AXI response codes
//   cmd_t / rsp_t : captured command and response, sized for the widest
//                   legal configuration (64-bit address and data); narrower
//                   instances zero-extend into these and truncate out.
package axil_init_pkg;

    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef struct packed {
        logic                  write;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_STRB_W-1:0] strb;
    } cmd_t;

    typedef struct packed {
        logic                  write;
        logic [MAX_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/axil_init_timer.sv
// Transaction watchdog: saturating up-counter with clear and enable.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (wins over en)
//   en         : count this cycle
//   hit        : the count after this edge equals THRESH (never when THRESH = 0)
// hit looks one edge ahead so the owner can register it on the very edge the
// threshold is reached, and a response captured on that same edge agrees
// with the sticky flag.
module axil_init_timer #(
    parameter int THRESH = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int             CW  = (THRESH < 2) ? 1 : $clog2(THRESH + 1);
    localparam logic [CW-1:0]  LIM = CW'(THRESH);
    localparam bit             ARMED = (THRESH != 0);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Saturates at the threshold: nothing beyond it is ever observed.
    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (en && cnt != LIM)
            cnt_nxt = cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    assign hit = ARMED && (cnt_nxt == LIM);

endmodule

// File: rtl/axil_cmd_initiator.sv
// AXI-Lite initiator driven by a single-beat command stream; used to program
// accelerator / power-manager register slaves without a CPU.
//   cmd_*   : command in (valid/ready), write flag, address, data, strobes
//   rsp_*   : response out (valid/ready), write echo, read data, resp, timeout
//   m_aw/w/b/ar/r_* : AXI-Lite master port, one transaction outstanding
//   busy    : FSM not idle
//   timeout_sticky : some transaction ran past TIMEOUT_CYCLES since reset
//   err_count      : saturating count of non-OKAY responses delivered
module axil_cmd_initiator
    import axil_init_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,  // 32 or 64
    parameter int TIMEOUT_CYCLES = 1024 // 0 disables the watchdog
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,

    output logic [ADDR_WIDTH-1:0]   m_aw_addr,
    output logic [2:0]              m_aw_prot,
    output logic                    m_aw_valid,
    input  logic                    m_aw_ready,
    output logic [DATA_WIDTH-1:0]   m_w_data,
    output logic [DATA_WIDTH/8-1:0] m_w_strb,
    output logic                    m_w_valid,
    input  logic                    m_w_ready,
    input  logic [1:0]              m_b_resp,
    input  logic                    m_b_valid,
    output logic                    m_b_ready,
    output logic [ADDR_WIDTH-1:0]   m_ar_addr,
    output logic [2:0]              m_ar_prot,
    output logic                    m_ar_valid,
    input  logic                    m_ar_ready,
    input  logic [DATA_WIDTH-1:0]   m_r_data,
    input  logic [1:0]              m_r_resp,
    input  logic                    m_r_valid,
    output logic                    m_r_ready,

    output logic                    busy,
    output logic                    timeout_sticky,
    output logic [7:0]              err_count
);

    state_t     state, state_nxt;
    cmd_t       cmd_q;
    rsp_t       rsp_q;
    logic       aw_pend, w_pend;   // AW / W beat still owed in WR_REQ
    logic       sticky_q;
    logic [7:0] err_q;
    logic       tmr_en, tmr_hit;

    logic cmd_hs, aw_hs, w_hs, b_hs, r_hs, rsp_hs;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = m_aw_valid && m_aw_ready;
    assign w_hs   = m_w_valid && m_w_ready;
    assign b_hs   = m_b_valid && m_b_ready;
    assign r_hs   = m_r_valid && m_r_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    // Next state and per-state handshake outputs.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        m_b_ready  = 1'b0;
        m_ar_valid = 1'b0;
        m_r_ready  = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = cmd_write ? WR_REQ : RD_REQ;
            end
            // Each beat is done if it already went or goes this edge, so the
            // same-cycle case and both orderings fall out naturally.
            WR_REQ: begin
                if ((!aw_pend || m_aw_ready) && (!w_pend || m_w_ready))
                    state_nxt = WR_RESP;
            end
            WR_RESP: begin
                m_b_ready = 1'b1;
                if (m_b_valid)
                    state_nxt = RSP;
            end
            RD_REQ: begin
                m_ar_valid = 1'b1;
                if (m_ar_ready)
                    state_nxt = RD_RESP;
            end
            RD_RESP: begin
                m_r_ready = 1'b1;
                if (m_r_valid)
                    state_nxt = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_q    <= '0;
            rsp_q    <= '0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            sticky_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state    <= state_nxt;
            sticky_q <= sticky_q | tmr_hit;

            if (cmd_hs) begin
                cmd_q.write <= cmd_write;
                cmd_q.addr  <= MAX_ADDR_W'(cmd_addr);
                cmd_q.data  <= MAX_DATA_W'(cmd_data);
                cmd_q.strb  <= MAX_STRB_W'(cmd_strb);
                aw_pend     <= cmd_write;
                w_pend      <= cmd_write;
            end else begin
                if (aw_hs) aw_pend <= 1'b0;
                if (w_hs)  w_pend  <= 1'b0;
            end

            if (b_hs) begin
                rsp_q.write   <= cmd_q.write;
                rsp_q.data    <= '0;
                rsp_q.resp    <= m_b_resp;
                rsp_q.timeout <= tmr_hit;
            end
            if (r_hs) begin
                rsp_q.write   <= cmd_q.write;
                rsp_q.data    <= MAX_DATA_W'(m_r_data);
                rsp_q.resp    <= m_r_resp;
                rsp_q.timeout <= tmr_hit;
            end

            if (rsp_hs && rsp_q.resp != OKAY && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    assign tmr_en = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);

    axil_init_timer #(
        .THRESH (TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cmd_hs),
        .en    (tmr_en),
        .hit   (tmr_hit)
    );

    assign m_aw_addr  = cmd_q.addr[ADDR_WIDTH-1:0];
    assign m_aw_prot  = 3'b000;
    assign m_aw_valid = aw_pend;
    assign m_w_data   = cmd_q.data[DATA_WIDTH-1:0];
    assign m_w_strb   = cmd_q.strb[DATA_WIDTH/8-1:0];
    assign m_w_valid  = w_pend;
    assign m_ar_addr  = cmd_q.addr[ADDR_WIDTH-1:0];
    assign m_ar_prot  = 3'b000;

    assign rsp_write   = rsp_q.write;
    assign rsp_data    = rsp_q.data[DATA_WIDTH-1:0];
    assign rsp_resp    = rsp_q.resp;
    assign rsp_timeout = rsp_q.timeout;

    assign busy           = (state != IDLE);
    assign timeout_sticky = sticky_q;
    assign err_count      = err_q;

    // Upper struct bits beyond the configured widths are never driven out.
    logic unused_bits;
    assign unused_bits = ^{cmd_q, rsp_q};

endmodule

// File: tb/tb_axil_cmd_initiator.sv
// Bench for axil_cmd_initiator: table vectors, random transactions and
// hand-written timeout / async-reset sequences, with the bench acting as
// the AXI-Lite slave and the response consumer.
module tb_axil_cmd_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_data;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
    logic [2:0]  m_aw_prot, m_ar_prot;
    logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_b_resp, m_r_resp;
    logic        m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic        busy, timeout_sticky;
    logic [7:0]  err_count;

    axil_cmd_initiator #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot), .m_aw_valid(m_aw_valid),
        .m_aw_ready(m_aw_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_b_resp(m_b_resp),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_ar_addr(m_ar_addr),
        .m_ar_prot(m_ar_prot), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid),
        .m_r_ready(m_r_ready), .busy(busy), .timeout_sticky(timeout_sticky),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // One transaction: command, slave delays (cycles after the accept edge
    // before the slave raises ready/valid), response hold-off, and the
    // expected accept-to-rsp_valid latency (-1: derive from the delays).
    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          hold;
        int          exp_lat;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int err_m = 0;       // expected err_count
    bit sticky_m = 1'b0; // expected timeout_sticky before the current txn

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_resp = 0;
        m_ar_ready = 0; m_r_valid = 0; m_r_data = 0; m_r_resp = 0;
        rsp_ready = 0;
    endtask

    task automatic run_txn(input vec_t v);
        int lat, aw_cyc, w_cyc, ar_cyc, aw_n, w_n, ar_n, b_n, r_n;
        int bad_rdy, bad_st, bad_fld, rsp_cyc, aw_e, w_e, ar_e, hs_e, m, exp_lat, tmin;
        bit done, to_seen, exp_to;
        logic [31:0] exp_data;
        lat = -1; aw_cyc = 0; w_cyc = 0; ar_cyc = 0; aw_n = 0; w_n = 0; ar_n = 0;
        b_n = 0; r_n = 0; bad_rdy = 0; bad_st = 0; bad_fld = 0; rsp_cyc = 0;
        aw_e = -1; w_e = -1; ar_e = -1; hs_e = 1 << 20; done = 0; to_seen = 0;
        exp_data = v.write ? 32'h0 : v.rdata;
        if (v.exp_lat >= 0)
            exp_lat = v.exp_lat;
        else if (v.write)
            exp_lat = ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + 1 + v.b_dly + 2;
        else
            exp_lat = v.ar_dly + 1 + v.r_dly + 2;

        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_data = v.data; cmd_strb = v.strb;
        @(negedge clk);
        cmd_valid = 0;

        // c = edges elapsed since the accept edge
        for (int c = 0; c < 200 && !done; c++) begin
            if (cmd_ready !== 1'b0 || busy !== 1'b1) bad_rdy++;
            tmin = (c < hs_e) ? c : hs_e;
            if (timeout_sticky !== (sticky_m || tmin >= 16)) bad_st++;

            m_aw_ready = v.write && c >= v.aw_dly;
            m_w_ready  = v.write && c >= v.w_dly;
            if (m_aw_valid) begin
                aw_cyc++;
                if (m_aw_addr !== v.addr || m_aw_prot !== 3'b000) bad_fld++;
                if (m_aw_ready) begin aw_n++; aw_e = c + 1; end
            end
            if (m_w_valid) begin
                w_cyc++;
                if (m_w_data !== v.data || m_w_strb !== v.strb) bad_fld++;
                if (m_w_ready) begin w_n++; w_e = c + 1; end
            end
            m = (aw_e > w_e) ? aw_e : w_e;
            m_b_valid = aw_e >= 0 && w_e >= 0 && b_n == 0 && c >= m + v.b_dly;
            m_b_resp  = v.resp;
            if (m_b_valid && m_b_ready) begin b_n++; hs_e = c + 1; end

            m_ar_ready = !v.write && c >= v.ar_dly;
            if (m_ar_valid) begin
                ar_cyc++;
                if (m_ar_addr !== v.addr || m_ar_prot !== 3'b000) bad_fld++;
                if (m_ar_ready) begin ar_n++; ar_e = c + 1; end
            end
            m_r_valid = ar_e >= 0 && r_n == 0 && c >= ar_e + v.r_dly;
            m_r_data  = v.rdata;
            m_r_resp  = v.resp;
            if (m_r_valid && m_r_ready) begin r_n++; hs_e = c + 1; end

            rsp_ready = 0;
            if (rsp_valid) begin
                if (rsp_cyc == 0) begin lat = c + 1; to_seen = rsp_timeout; end
                rsp_cyc++;
                if (rsp_write !== v.write || rsp_data !== exp_data || rsp_resp !== v.resp ||
                    rsp_timeout !== to_seen || err_count !== 8'(err_m)) bad_fld++;
                rsp_ready = rsp_cyc > v.hold;
                done = rsp_ready;
            end
            @(negedge clk);
        end
        idle_bus();

        exp_to = hs_e >= 16;
        if (v.resp != 2'b00 && err_m < 255) err_m++;
        chk("txn_done", done, 1);
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_timeout", to_seen, exp_to);
        chk("rsp_fields_stable", bad_fld, 0);
        chk("cmd_ready_busy", bad_rdy, 0);
        chk("sticky_track", bad_st, 0);
        chk("err_count", err_count, err_m);
        sticky_m = sticky_m | exp_to;
        if (v.write) begin
            chk("aw_beats", aw_n, 1);
            chk("w_beats", w_n, 1);
            chk("b_beats", b_n, 1);
            chk("aw_valid_cycles", aw_cyc, v.aw_dly + 1);
            chk("w_valid_cycles", w_cyc, v.w_dly + 1);
            chk("ar_on_write", ar_cyc, 0);
        end else begin
            chk("ar_beats", ar_n, 1);
            chk("r_beats", r_n, 1);
            chk("ar_valid_cycles", ar_cyc, v.ar_dly + 1);
            chk("aw_w_on_read", aw_cyc + w_cyc, 0);
        end
    endtask

    vec_t tbl[7];
    vec_t v;

    initial begin
        idle_bus();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_data = 0; cmd_strb = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_valids", {m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready, rsp_valid, busy}, 0);
        chk("reset_status", {err_count, timeout_sticky, rsp_timeout, rsp_resp}, 0);
        chk("reset_regs", {m_aw_addr, m_w_data, rsp_data}, 0);
        rst_n = 1;
        @(negedge clk);

        //            wr addr          data           strb  aw w  b  ar r  rdata          resp   hold lat
        tbl[0] = '{1, 32'h0000_2004, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0, 32'h0,          2'b00, 0,   3};
        tbl[1] = '{1, 32'h0000_201C, 32'hA5A5_0001, 4'hF, 2, 0, 0, 0, 0, 32'h0,          2'b00, 0,   5};
        tbl[2] = '{0, 32'h0000_2000, 32'h0,         4'h0, 0, 0, 0, 0, 5, 32'h1234_5678,  2'b00, 0,   8};
        tbl[3] = '{0, 32'h0000_2008, 32'h0,         4'h0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF,  2'b10, 4,   3};
        tbl[4] = '{1, 32'h0000_3000, 32'hCAFE_F00D, 4'h3, 1, 3, 2, 0, 0, 32'h0,          2'b11, 1,   8};
        tbl[5] = '{1, 32'h0000_3010, 32'h0BAD_CAFE, 4'hC, 2, 2, 0, 0, 0, 32'h0,          2'b01, 2,   5};
        tbl[6] = '{0, 32'h0000_3020, 32'h0,         4'h0, 0, 0, 0, 3, 1, 32'h0F0F_0F0F,  2'b00, 0,   7};
        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            v.write  = 1'($urandom_range(0, 1));
            v.addr   = $urandom & 32'h0000_FFFC;
            v.data   = $urandom;
            v.strb   = 4'($urandom_range(1, 15));
            v.aw_dly = $urandom_range(0, 3);
            v.w_dly  = $urandom_range(0, 3);
            v.b_dly  = $urandom_range(0, 3);
            v.ar_dly = $urandom_range(0, 3);
            v.r_dly  = $urandom_range(0, 3);
            v.rdata  = $urandom;
            v.resp   = 2'($urandom_range(0, 3));
            v.hold   = $urandom_range(0, 3);
            v.exp_lat = -1;
            run_txn(v);
        end

        // B held off 20 cycles: sticky must rise on the 16th edge, the
        // response carries the timeout, and the next command is clean.
        v = '{1, 32'h0000_2010, 32'h5, 4'hF, 0, 0, 20, 0, 0, 32'h0, 2'b00, 0, 23};
        run_txn(v);
        chk("sticky_after_timeout", timeout_sticky, 1);
        run_txn(tbl[2]);

        // Async reset while waiting on R.
        v = tbl[2];
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0000_2040; cmd_data = 0; cmd_strb = 0;
        @(negedge clk);
        cmd_valid = 0; m_ar_ready = 1;
        @(negedge clk);
        m_ar_ready = 0;
        chk("pre_reset_r_ready", m_r_ready, 1);
        chk("pre_reset_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_ar_valid", m_ar_valid, 0);
        chk("arst_r_ready", m_r_ready, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err_count", err_count, 0);
        chk("arst_sticky", timeout_sticky, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        err_m = 0; sticky_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1);
        run_txn(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
